// File: rtl/vga_timing_pkg.sv
// 640x480@72 Hz timing constants shared by the VGA output and return paths,
// plus the frame decoder state encoding.
package vga_timing_pkg;

    localparam int   VGA_H_TOTAL     = 832;
    localparam int   VGA_H_OFFSET    = 168;
    localparam int   VGA_H_VISIBLE   = 640;
    localparam int   VGA_V_TOTAL     = 520;
    localparam int   VGA_V_OFFSET    = 31;
    localparam int   VGA_V_VISIBLE   = 480;
    localparam logic VGA_SYNC_ACTIVE = 1'b0;
    localparam int   VGA_LOCK_FRAMES = 2;

    localparam int   CNT_W   = 10;
    localparam int   WHITE_W = 19;
    localparam int   ERR_W   = 8;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } vga_state_t;

endpackage

// File: rtl/vga_sync_edge.sv
// Input registers and leading-edge detection for hsync/vsync, plus the
// registered black/white sample.
module vga_sync_edge
    import vga_timing_pkg::*;
#(
    parameter logic SYNC_ACTIVE = VGA_SYNC_ACTIVE
) (
    input  logic clk,
    input  logic reset_n,
    input  logic hsync_in,
    input  logic vsync_in,
    input  logic bw_in,
    output logic hs_edge,
    output logic vs_edge,
    output logic bw_q
);

    logic [1:0] sync_in;
    logic [1:0] sync_q_reg;
    logic [1:0] sync_p_reg;
    logic [1:0] edge_det;

    assign sync_in = {vsync_in, hsync_in};

    // Flops reset to the active level so a sync pulse already in progress
    // when reset is released is not mistaken for a leading edge.
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sync_q_reg[gi] <= SYNC_ACTIVE;
                sync_p_reg[gi] <= SYNC_ACTIVE;
            end else begin
                sync_q_reg[gi] <= sync_in[gi];
                sync_p_reg[gi] <= sync_q_reg[gi];
            end
        end
        assign edge_det[gi] = (sync_q_reg[gi] == SYNC_ACTIVE) &&
                              (sync_p_reg[gi] != SYNC_ACTIVE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bw_q <= 1'b0;
        end else begin
            bw_q <= bw_in;
        end
    end

    assign hs_edge = edge_det[0];
    assign vs_edge = edge_det[1];

endmodule

// File: rtl/vga_frame_decoder.sv
// Receive-side VGA timing checker: locks onto hsync/vsync, recovers pixel
// coordinates and counts white visible pixels per locked frame.
module vga_frame_decoder
    import vga_timing_pkg::*;
#(
    parameter int   H_TOTAL     = VGA_H_TOTAL,
    parameter int   H_OFFSET    = VGA_H_OFFSET,
    parameter int   H_VISIBLE   = VGA_H_VISIBLE,
    parameter int   V_TOTAL     = VGA_V_TOTAL,
    parameter int   V_OFFSET    = VGA_V_OFFSET,
    parameter int   V_VISIBLE   = VGA_V_VISIBLE,
    parameter logic SYNC_ACTIVE = VGA_SYNC_ACTIVE,
    parameter int   LOCK_FRAMES = VGA_LOCK_FRAMES
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic               bw_in,
    output logic               locked,
    output logic               pix_valid,
    output logic [CNT_W-1:0]   pix_x,
    output logic [CNT_W-1:0]   pix_y,
    output logic               pix_bw,
    output logic               frame_pulse,
    output logic [WHITE_W-1:0] frame_white,
    output logic [ERR_W-1:0]   err_count
);

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LOST = CNT_W'(V_TOTAL + 7);
    localparam logic [CNT_W-1:0] H_MAX  = '1;
    localparam logic [CNT_W-1:0] H_NEAR = H_MAX - CNT_W'(1);
    localparam logic [CNT_W-1:0] H_LO   = CNT_W'(H_OFFSET);
    localparam logic [CNT_W-1:0] H_HI   = CNT_W'(H_OFFSET + H_VISIBLE);
    localparam logic [CNT_W-1:0] V_LO   = CNT_W'(V_OFFSET);
    localparam logic [CNT_W-1:0] V_HI   = CNT_W'(V_OFFSET + V_VISIBLE);
    localparam logic [3:0]       LOCK_N = 4'(LOCK_FRAMES);

    logic hs_edge, vs_edge, bw_q;

    vga_sync_edge #(
        .SYNC_ACTIVE (SYNC_ACTIVE)
    ) u_sync_edge (
        .clk      (clk),
        .reset_n  (reset_n),
        .hsync_in (hsync_in),
        .vsync_in (vsync_in),
        .bw_in    (bw_in),
        .hs_edge  (hs_edge),
        .vs_edge  (vs_edge),
        .bw_q     (bw_q)
    );

    vga_state_t           state_reg, state_next;
    logic [CNT_W-1:0]     h_cnt_reg, h_cnt_next;
    logic [CNT_W-1:0]     v_cnt_reg, v_cnt_next;
    logic [3:0]           good_reg, good_next, good_inc;
    logic                 exempt_reg, exempt_next;
    logic                 dirty_reg, dirty_next;
    logic [WHITE_W-1:0]   acc_reg, acc_next, acc_sum;
    logic [WHITE_W-1:0]   white_reg, white_next;
    logic                 pulse_reg, pulse_next;
    logic [ERR_W-1:0]     err_reg, err_next;
    logic                 h_err, h_lost, v_err, v_lost, mismatch;

    logic                 pix_valid_reg, pix_bw_reg, in_win;
    logic [CNT_W-1:0]     pix_x_reg, pix_y_reg;

    always_comb begin
        h_cnt_next  = hs_edge ? '0 : ((h_cnt_reg == H_MAX) ? H_MAX : h_cnt_reg + CNT_W'(1));
        v_cnt_next  = vs_edge ? '0 : (hs_edge ? v_cnt_reg + CNT_W'(1) : v_cnt_reg);
        h_err       = hs_edge && !exempt_reg && (h_cnt_reg != H_LAST);
        h_lost      = !hs_edge && (h_cnt_reg == H_NEAR);
        v_err       = vs_edge && (v_cnt_reg != V_LAST);
        v_lost      = hs_edge && !vs_edge && (v_cnt_reg == V_LOST);
        mismatch    = h_err || h_lost || v_err || v_lost;
        good_inc    = good_reg + 4'd1;
        acc_sum     = acc_reg + WHITE_W'(pix_valid_reg && pix_bw_reg);

        state_next  = state_reg;
        good_next   = good_reg;
        exempt_next = hs_edge ? 1'b0 : exempt_reg;
        dirty_next  = vs_edge ? 1'b0 : (dirty_reg || mismatch);
        acc_next    = '0;
        white_next  = white_reg;
        pulse_next  = 1'b0;
        err_next    = err_reg;

        if (mismatch && (state_reg != SEARCH) && (err_reg != '1))
            err_next = err_reg + ERR_W'(1);

        case (state_reg)
            SEARCH: begin
                exempt_next = 1'b1;
                dirty_next  = 1'b0;
                if (vs_edge) begin
                    h_cnt_next = '0;
                    v_cnt_next = '0;
                    good_next  = '0;
                    state_next = MEASURE;
                end
            end
            MEASURE: begin
                if (mismatch) begin
                    good_next = '0;
                end else if (vs_edge && !dirty_reg) begin
                    good_next = good_inc;
                    if (good_inc >= LOCK_N)
                        state_next = LOCKED;
                end
            end
            LOCKED: begin
                // A broken frame is dropped entirely: no pulse, count discarded.
                if (mismatch) begin
                    state_next = SEARCH;
                end else if (vs_edge) begin
                    white_next = acc_sum;
                    pulse_next = 1'b1;
                end else begin
                    acc_next = acc_sum;
                end
            end
            default: state_next = SEARCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= SEARCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt_reg  <= '0;
            v_cnt_reg  <= '0;
            good_reg   <= '0;
            exempt_reg <= 1'b1;
            dirty_reg  <= 1'b0;
            acc_reg    <= '0;
            white_reg  <= '0;
            pulse_reg  <= 1'b0;
            err_reg    <= '0;
        end else begin
            h_cnt_reg  <= h_cnt_next;
            v_cnt_reg  <= v_cnt_next;
            good_reg   <= good_next;
            exempt_reg <= exempt_next;
            dirty_reg  <= dirty_next;
            acc_reg    <= acc_next;
            white_reg  <= white_next;
            pulse_reg  <= pulse_next;
            err_reg    <= err_next;
        end
    end

    // Counters lag the bw sample by one cycle, so h_cnt here lines up with bw_q.
    always_comb begin
        in_win = (state_reg == LOCKED) &&
                 (h_cnt_reg >= H_LO) && (h_cnt_reg < H_HI) &&
                 (v_cnt_reg >= V_LO) && (v_cnt_reg < V_HI);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_valid_reg <= 1'b0;
            pix_x_reg     <= '0;
            pix_y_reg     <= '0;
            pix_bw_reg    <= 1'b0;
        end else begin
            pix_valid_reg <= in_win;
            pix_x_reg     <= in_win ? h_cnt_reg - H_LO : '0;
            pix_y_reg     <= in_win ? v_cnt_reg - V_LO : '0;
            pix_bw_reg    <= in_win && bw_q;
        end
    end

    assign locked      = (state_reg == LOCKED);
    assign pix_valid   = pix_valid_reg;
    assign pix_x       = pix_x_reg;
    assign pix_y       = pix_y_reg;
    assign pix_bw      = pix_bw_reg;
    assign frame_pulse = pulse_reg;
    assign frame_white = white_reg;
    assign err_count   = err_reg;

endmodule

// File: tb/tb_vga_frame_decoder.sv
// Directed bench for vga_frame_decoder on a scaled 48x32 raster (short frames),
// with one active-low and one active-high sync instance driven in parallel.
module tb_vga_frame_decoder;

    localparam int HT = 48, HO = 12, HV = 32, VT = 32, VO = 3, VV = 24;
    localparam int FRAME = HT * VT;       // 1536 clocks per frame
    localparam int WHITE_ALL = HV * VV;   // 768 visible pixels
    localparam int PX_X = 5, PX_Y = 7;
    localparam int PX_H = HO + PX_X + 1;  // counters lag the raw input by one clock
    localparam int PX_V = VO + PX_Y;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic hs_n = 1'b1, vs_n = 1'b1, hs_p = 1'b0, vs_p = 1'b0, bw_in = 1'b0;

    logic        locked0, pix_valid0, pix_bw0, frame_pulse0;
    logic [9:0]  pix_x0, pix_y0;
    logic [18:0] frame_white0;
    logic [7:0]  err_count0;
    logic        locked1, pix_valid1, pix_bw1, frame_pulse1;
    logic [9:0]  pix_x1, pix_y1;
    logic [18:0] frame_white1;
    logic [7:0]  err_count1;

    vga_frame_decoder #(
        .H_TOTAL(HT), .H_OFFSET(HO), .H_VISIBLE(HV),
        .V_TOTAL(VT), .V_OFFSET(VO), .V_VISIBLE(VV),
        .SYNC_ACTIVE(1'b0), .LOCK_FRAMES(2)
    ) u0 (
        .clk(clk), .reset_n(reset_n), .hsync_in(hs_n), .vsync_in(vs_n), .bw_in(bw_in),
        .locked(locked0), .pix_valid(pix_valid0), .pix_x(pix_x0), .pix_y(pix_y0),
        .pix_bw(pix_bw0), .frame_pulse(frame_pulse0), .frame_white(frame_white0),
        .err_count(err_count0)
    );

    vga_frame_decoder #(
        .H_TOTAL(HT), .H_OFFSET(HO), .H_VISIBLE(HV),
        .V_TOTAL(VT), .V_OFFSET(VO), .V_VISIBLE(VV),
        .SYNC_ACTIVE(1'b1), .LOCK_FRAMES(2)
    ) u1 (
        .clk(clk), .reset_n(reset_n), .hsync_in(hs_p), .vsync_in(vs_p), .bw_in(bw_in),
        .locked(locked1), .pix_valid(pix_valid1), .pix_x(pix_x1), .pix_y(pix_y1),
        .pix_bw(pix_bw1), .frame_pulse(frame_pulse1), .frame_white(frame_white1),
        .err_count(err_count1)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int pe_cnt = 0;

    always @(posedge clk) pe_cnt <= pe_cnt + 1;

    // Raster generator state, driven on the falling edge
    int gen_h = 0, gen_v = 10, h_len = HT;
    int vs_starts = 0, line_pe = 0, px_pe = 0;
    bit bw_all = 1'b0, bw_one = 1'b0, short_req = 1'b0, kill_en = 1'b0;

    initial begin
        bit hs_act, vs_act;
        forever begin
            @(negedge clk);
            hs_act = (gen_h < 4) && !(kill_en && gen_v >= 1 && gen_v <= 23);
            vs_act = (gen_v == 0);
            hs_n = !hs_act; vs_n = !vs_act;
            hs_p = hs_act;  vs_p = vs_act;
            bw_in = bw_all || (bw_one && gen_h == PX_H && gen_v == PX_V);
            if (bw_one && gen_h == PX_H && gen_v == PX_V) px_pe = pe_cnt;
            if (gen_h == 0) begin
                line_pe = pe_cnt;
                if (gen_v == 0) vs_starts++;
            end
            gen_h++;
            if (gen_h >= h_len) begin
                gen_h = 0;
                h_len = short_req ? HT - 1 : HT;
                short_req = 1'b0;
                gen_v = (gen_v + 1) % VT;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns on the first sample after the n-th vsync leading edge was driven.
    task automatic wait_vs(input int n, input string tag);
        int start;
        int i;
        start = vs_starts;
        for (i = 0; i < n * FRAME + 200 && vs_starts < start + n; i++) tick();
        check(tag, vs_starts - start, n);
    endtask

    task automatic wait_pulse(output int pe, input string tag);
        int i;
        for (i = 0; i < FRAME + 200 && !frame_pulse0; i++) tick();
        pe = pe_cnt;
        check(tag, frame_pulse0, 1);
    endtask

    task automatic wait_line(input int v, input string tag);
        for (int i = 0; i < FRAME + 200 && gen_v != v; i++) tick();
        check(tag, gen_v, v);
    endtask

    task automatic check_lock_edge(input string tag);
        check({tag, "_pre0"}, locked0, 0);
        check({tag, "_pre1"}, locked1, 0);
        tick();
        check({tag, "_lock0"}, locked0, 1);
        check({tag, "_lock1"}, locked1, 1);
    endtask

    initial begin
        int p1, p2, e0, seen;
        bw_all = 1'b1;
        repeat (3) tick();
        check("rst_locked", locked0, 0);
        check("rst_pix_valid", pix_valid0, 0);
        check("rst_err", err_count0, 0);
        check("rst_white", frame_white0, 0);
        reset_n = 1'b1;

        // Initial lock (SEARCH + 2 clean frames), then all-white frames
        wait_vs(3, "a_vs3");
        check_lock_edge("a");
        check("a_err", err_count0, 0);
        wait_pulse(p1, "a_pulse1");
        check("a_white", frame_white0, WHITE_ALL);
        tick();
        check("a_pulse_width", frame_pulse0, 0);
        wait_pulse(p2, "a_pulse2");
        check("a_period", p2 - p1, FRAME);
        check("a_white0", frame_white0, WHITE_ALL);
        check("a_white1", frame_white1, WHITE_ALL);

        // Reset asserted mid-frame: outputs drop without a clock edge
        wait_line(20, "b_line20");
        #1 reset_n = 1'b0;
        #1;
        check("b_locked0", locked0, 0);
        check("b_locked1", locked1, 0);
        check("b_pix_valid", pix_valid0, 0);
        check("b_pix_x", pix_x0, 0);
        check("b_white", frame_white0, 0);
        check("b_err", err_count0, 0);
        tick();
        reset_n = 1'b1;
        bw_all = 1'b0;
        wait_vs(3, "b_vs3");
        check_lock_edge("b");
        check("b_err_after", err_count0, 0);

        // Single white pixel at (5,7)
        bw_one = 1'b1;
        for (int i = 0; i < 2 * FRAME && !(pix_valid0 && pix_bw0); i++) tick();
        check("c_seen", pix_valid0 && pix_bw0, 1);
        check("c_latency", pe_cnt - px_pe, 2);
        check("c_x0", pix_x0, PX_X);
        check("c_y0", pix_y0, PX_Y);
        check("c_x1", pix_x1, PX_X);
        check("c_y1", pix_y1, PX_Y);
        check("c_bw1", pix_bw1, 1);
        bw_one = 1'b0;
        tick();
        check("c_bw_next", pix_bw0, 0);
        check("c_x_next", pix_x0, PX_X + 1);
        wait_pulse(p1, "c_pulse");
        check("c_white0", frame_white0, 1);
        check("c_white1", frame_white1, 1);

        // One line shortened by a clock
        wait_line(12, "d_line12");
        short_req = 1'b1;
        e0 = err_count0;
        for (int i = 0; i < 4 * HT && locked0; i++) tick();
        check("d_unlock0", locked0, 0);
        check("d_unlock_lat", pe_cnt - line_pe, 2);
        check("d_err0", err_count0, e0 + 1);
        check("d_unlock1", locked1, 0);
        check("d_err1", err_count1, e0 + 1);
        seen = 0;
        for (int i = 0; i < FRAME + 200 && vs_starts == 0; i++) tick();
        wait_vs(1, "d_vs1");
        for (int i = 0; i < 4; i++) begin
            if (frame_pulse0 || frame_pulse1) seen++;
            tick();
        end
        check("d_no_pulse", seen, 0);
        wait_vs(2, "d_vs2");
        check_lock_edge("d");

        // hsync lost for most of a frame
        wait_vs(1, "e_vs");
        kill_en = 1'b1;
        e0 = err_count0;
        for (int i = 0; i < FRAME && locked0; i++) tick();
        check("e_unlock", locked0, 0);
        check("e_err_once", err_count0, e0 + 1);
        wait_line(25, "e_line25");
        kill_en = 1'b0;
        check("e_err_hold", err_count0, e0 + 1);
        wait_vs(3, "e_vs3");
        check_lock_edge("e");
        check("e_err_final0", err_count0, e0 + 1);
        check("e_err_final1", err_count1, e0 + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
